// File: rtl/mii_tx_framer_if.sv
// Upstream byte pacing handshake plus MII TX pins and status of mii_tx_framer.
// master = byte generator / PHY side, slave = the framer itself.
interface mii_tx_framer_if;
  logic        advance;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_enable;
  logic        tx_en;
  logic [3:0]  txd;
  logic        tx_busy;
  logic        overrun;
  logic [15:0] frame_count;

  modport master (
    input  advance, tx_en, txd, tx_busy, overrun, frame_count,
    output data, data_valid, data_enable
  );

  modport slave (
    output advance, tx_en, txd, tx_busy, overrun, frame_count,
    input  data, data_valid, data_enable
  );
endinterface

// File: rtl/mii_tx_framer.sv
// Byte stream to 100 Mb/s MII nibbles with preamble/SFD, CRC-32 FCS and IFG.
// Optional zero padding to MIN_FRAME bytes is compiled in with MII_TX_PAD_EN.
module mii_tx_framer #(
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned MIN_FRAME = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  mii_tx_framer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
`ifdef MII_TX_PAD_EN
    S_PAD  = 3'd4,
`endif
    S_FCS  = 3'd5,
    S_IFG  = 3'd6
  } state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic        advance_q, advance_d;
  logic        slot_q, slot_d;
  logic        prev_valid_q, prev_valid_d;
  logic        drop_q, drop_d;
  logic        overrun_q, overrun_d;
  logic [8:0]  dl_q [8];
  logic [8:0]  dl_d [8];
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic [3:0]  txd_q, txd_d;
  logic [3:0]  hi_q, hi_d;
  logic [15:0] frame_count_q, frame_count_d;
`ifdef MII_TX_PAD_EN
  logic [10:0] bc_q, bc_d, bc_inc_s;
`endif

  logic        in_valid_s;
  logic        start_s;
  logic [8:0]  dl_out_s;
  logic [31:0] fcs_s;
  logic [7:0]  byte_s;
  logic        emit_s;

  // Next-state: pacing, delay line, framing FSM and nibble serialiser.
  always_comb begin
    in_valid_s    = bus.data_valid & bus.data_enable;
    start_s       = slot_q & in_valid_s & ~prev_valid_q;
    dl_out_s      = dl_q[7];
    fcs_s         = ~crc_q;
    phase_d       = ~phase_q;
    advance_d     = ~phase_q;
    slot_d        = advance_q;
    state_d       = state_q;
    prev_valid_d  = prev_valid_q;
    drop_d        = drop_q;
    overrun_d     = 1'b0;
    dl_d          = dl_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    tx_en_d       = tx_en_q;
    txd_d         = txd_q;
    hi_d          = hi_q;
    frame_count_d = frame_count_q;
    byte_s        = 8'h00;
    emit_s        = 1'b0;
`ifdef MII_TX_PAD_EN
    bc_d          = bc_q;
    bc_inc_s      = (bc_q == 11'd2047) ? bc_q : bc_q + 11'd1;
`endif

    if (slot_q) begin
      prev_valid_d = in_valid_s;
      if (start_s && (state_q != S_IDLE)) begin
        overrun_d = 1'b1;
        drop_d    = 1'b1;
      end else if (!in_valid_s) begin
        drop_d = 1'b0;
      end else begin
        drop_d = drop_q;
      end
      // A dropped frame must never reach the line, so its bytes enter as invalid.
      dl_d[0] = {in_valid_s & ~drop_d, bus.data};
      for (int i = 1; i < 8; i++) begin
        dl_d[i] = dl_q[i-1];
      end

      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            emit_s  = 1'b1;
            byte_s  = 8'h55;
            state_d = S_PRE;
            cnt_d   = 8'd1;
            crc_d   = 32'hFFFF_FFFF;
`ifdef MII_TX_PAD_EN
            bc_d    = 11'd0;
`endif
          end else begin
            emit_s = 1'b0;
          end
        end
        S_PRE: begin
          emit_s = 1'b1;
          byte_s = 8'h55;
          if (cnt_q == 8'd6) begin
            state_d = S_SFD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_SFD: begin
          emit_s  = 1'b1;
          byte_s  = 8'hD5;
          state_d = S_DATA;
        end
        S_DATA: begin
          emit_s = 1'b1;
          if (dl_out_s[8]) begin
            byte_s = dl_out_s[7:0];
            crc_d  = crc32_byte(crc_q, dl_out_s[7:0]);
`ifdef MII_TX_PAD_EN
            bc_d   = bc_inc_s;
          end else if (32'(bc_q) < MIN_FRAME) begin
            byte_s  = 8'h00;
            crc_d   = crc32_byte(crc_q, 8'h00);
            bc_d    = bc_inc_s;
            cnt_d   = 8'd0;
            state_d = (32'(bc_inc_s) >= MIN_FRAME) ? S_FCS : S_PAD;
`endif
          end else begin
            // First FCS byte goes out in the slot that found the line empty.
            byte_s  = fcs_s[7:0];
            state_d = S_FCS;
            cnt_d   = 8'd1;
          end
        end
`ifdef MII_TX_PAD_EN
        S_PAD: begin
          emit_s = 1'b1;
          byte_s = 8'h00;
          crc_d  = crc32_byte(crc_q, 8'h00);
          bc_d   = bc_inc_s;
          if (32'(bc_inc_s) >= MIN_FRAME) begin
            state_d = S_FCS;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_PAD;
          end
        end
`endif
        S_FCS: begin
          emit_s = 1'b1;
          byte_s = fcs_s[{cnt_q[1:0], 3'b000} +: 8];
          if (cnt_q == 8'd3) begin
            state_d = S_IFG;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_IFG: begin
          emit_s = 1'b0;
          if (32'(cnt_q) == IFG_BYTES - 32'd1) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase

      tx_en_d = emit_s;
      txd_d   = byte_s[3:0];
      hi_d    = byte_s[7:4];
    end else begin
      txd_d = hi_q;
      // IFG with count 0 on a non-slot clock is exactly the last FCS nibble.
      if ((state_q == S_IFG) && (cnt_q == 8'd0)) frame_count_d = frame_count_q + 16'd1;
      else                                      frame_count_d = frame_count_q;
    end
  end

  // All state registers; asynchronous reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      advance_q     <= 1'b0;
      slot_q        <= 1'b0;
      prev_valid_q  <= 1'b0;
      drop_q        <= 1'b0;
      overrun_q     <= 1'b0;
      dl_q          <= '{default: 9'd0};
      cnt_q         <= 8'd0;
      crc_q         <= 32'hFFFF_FFFF;
      tx_en_q       <= 1'b0;
      txd_q         <= 4'd0;
      hi_q          <= 4'd0;
      frame_count_q <= 16'd0;
`ifdef MII_TX_PAD_EN
      bc_q          <= 11'd0;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      advance_q     <= advance_d;
      slot_q        <= slot_d;
      prev_valid_q  <= prev_valid_d;
      drop_q        <= drop_d;
      overrun_q     <= overrun_d;
      dl_q          <= dl_d;
      cnt_q         <= cnt_d;
      crc_q         <= crc_d;
      tx_en_q       <= tx_en_d;
      txd_q         <= txd_d;
      hi_q          <= hi_d;
      frame_count_q <= frame_count_d;
`ifdef MII_TX_PAD_EN
      bc_q          <= bc_d;
`endif
    end
  end

  assign bus.advance     = advance_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.txd         = txd_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_count_q;
  assign bus.tx_busy     = (state_q != S_IDLE);

endmodule
